pbus_arbiter: RTL and testbench
===============================

Name: pbus_arbiter

Overview:
Two-master arbiter for the CPU's memory-mapped peripheral bus (addresses with addr[31:30]==2'b11). Master 0 is the CPU data port; master 1 is a secondary requester such as a debug or loader engine. The block grants the single peripheral slave port to one master at a time, using round-robin, and registers the request fields. It waits for the slave's ready, returns read data and status, and optionally aborts hung transfers on timeout.

Parameters:
TIMEOUT_CYCLES, 15, number of BUSY cycles without s_ready before abort (only with PBUS_ARB_TIMEOUT_EN); legal range 1..255.

Ports:
clock  in  1  system clock; all state updates on its rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
m0_addr  in  32  master 0 address
m0_wdata  in  32  master 0 write data
m0_size  in  3  one-hot size: bit0 = 1 byte, bit1 = 2 bytes, bit2 = 4 bytes
m0_read_req  in  1  master 0 read request, level
m0_write_req  in  1  master 0 write request, level
m0_rdata  out  32  read data returned to master 0
m0_ready  out  1  one-cycle completion pulse to master 0
m0_err  out  1  timeout flag, qualified by m0_ready
m1_*  same set as m0_*, for master 1
s_addr  out  32  slave address
s_wdata  out  32  slave write data
s_size  out  3  slave size, same one-hot encoding
s_read_req  out  1  slave read strobe
s_write_req  out  1  slave write strobe
s_rdata  in  32  slave read data, valid when s_ready=1
s_ready  in  1  slave completion, one cycle

Behaviour:
- All outputs are registered. Reset drives every output to 0, sets state to IDLE, sets last_grant to 1 (so master 0 wins the first tie) and clears the timeout counter.
- States: IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - A master is requesting if read_req|write_req is high.
  - If exactly one master is requesting, grant it.
  - If both are requesting, grant the master that is not last_grant.
  - On grant: latch addr, wdata, size and op; set last_grant to the granted master; go to BUSY.
  - With no request, stay in IDLE with all s_* outputs at 0.
- Both read_req and write_req high on one master: treat as a write; the read is ignored.
- BUSY:
  - s_addr, s_wdata and s_size come from the latched values.
  - Exactly one of s_read_req / s_write_req is held at 1 until s_ready is sampled high.
  - On s_ready=1: capture s_rdata (capture 0 for writes), drop the s_*_req strobe, go to DONE.
- DONE:
  - The granted master's mN_ready=1 for exactly one cycle, with mN_rdata valid.
  - The other master's ready, err and rdata stay 0.
  - Next state is IDLE.
- Latency: request sampled in IDLE at edge N -> slave strobe high during cycle N+1. If s_ready is high in cycle N+1, mN_ready is high in cycle N+2. Minimum round trip is 3 cycles per transfer.
- Masters hold the request fields stable until mN_ready. A request still high in the cycle after mN_ready is a new request.
- A master that drops its request mid-BUSY does not cancel the transfer. It completes and the ready pulse is still issued.
- Requests arriving while BUSY or DONE are not sampled. They wait for IDLE.
- A request from the non-granted master during DONE is granted in the following IDLE cycle, ahead of a re-request from the previous winner.
- s_ready while in IDLE or DONE is ignored.
- Reset asserted in any state aborts immediately:
  - s_*_req drop on the next edge;
  - no ready pulse is issued;
  - the lost transfer is not replayed.

Optional Feature:
PBUS_ARB_TIMEOUT_EN
- Defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle without s_ready.
  - When it reaches TIMEOUT_CYCLES, go to DONE with mN_err=1 and mN_rdata=32'hFFFFFFFF, and drop the s_*_req strobe.
  - s_ready in the same cycle as expiry takes priority: normal completion, err=0.
- Not defined:
  - No counter is built.
  - BUSY waits indefinitely.
  - m0_err and m1_err are tied to 0.

Test Plan:
- Reset: hold reset=0 for 3 cycles with both masters requesting -> all outputs 0; after release, m0 is granted first; s_read_req rises 1 cycle after the first sampled request.
- Single read: m0 reads 32'hC0000004, size 3'b100; slave returns s_rdata=32'h12345678 with s_ready in the first BUSY cycle -> m0_ready pulses exactly 2 cycles after the grant edge with m0_rdata=32'h12345678; m0_err=0.
- Contention: m0 and m1 each request continuously for 4 transfers -> grant order m0, m1, m0, m1; s_addr always matches the granted master's address; each mN_ready is one cycle only.
- Write stall: m1 writes 32'hDEADBEEF to 32'hC0000010, size 3'b001; s_ready held low for 5 cycles -> s_write_req is high for exactly 6 cycles with stable s_wdata; m1_ready follows with m1_rdata=0.
- Timeout (PBUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): s_ready never asserted -> strobe drops after 4 BUSY cycles; m0_ready=1, m0_err=1, m0_rdata=32'hFFFFFFFF. Repeat with s_ready arriving on the expiry cycle -> err=0 and slave data returned.
- Mid-operation reset and abandoned request:
  - Drive reset=0 in BUSY -> strobe low next cycle, no ready pulse.
  - Separately, m0 drops its request in BUSY -> transfer completes and m0_ready still pulses.

Source files
------------

// File: rtl/pbus_arbiter_if.sv
// One point-to-point peripheral bus link; instantiated once per master and once for the slave.
interface pbus_arbiter_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic        read_req;
    logic        write_req;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    modport master (
        output addr, wdata, size, read_req, write_req,
        input  rdata, ready, err
    );

    modport slave (
        input  addr, wdata, size, read_req, write_req,
        output rdata, ready, err
    );
endinterface

// File: rtl/pbus_arbiter.sv
// Round-robin two-master arbiter for the peripheral bus (addr[31:30] == 2'b11).
// Define PBUS_ARB_TIMEOUT_EN to abort transfers whose slave never returns ready.
module pbus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic           clock,
    input  logic           reset,
    pbus_arbiter_if.slave  m0,
    pbus_arbiter_if.slave  m1,
    pbus_arbiter_if.master s
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 3;

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("pbus_arbiter: TIMEOUT_CYCLES must be within 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] size;
        logic          wr;
    } req_t;

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic          gnt_q, gnt_d;
    req_t          req_q, req_d;
    logic [AW-1:0] s_addr_q, s_addr_d;
    logic [DW-1:0] s_wdata_q, s_wdata_d;
    logic [SW-1:0] s_size_q, s_size_d;
    logic          s_rd_q, s_rd_d;
    logic          s_wr_q, s_wr_d;
    logic [DW-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic          m0_ready_q, m0_ready_d, m1_ready_q, m1_ready_d;
    logic          m0_err_q, m0_err_d, m1_err_q, m1_err_d;

    logic          m0_req_c, m1_req_c, pick1_c, expire_c;
    logic [DW-1:0] rsp_data_c;
    req_t          m0_pkt_c, m1_pkt_c, sel_pkt_c;

    // A simultaneous read+write request is a write.
    assign m0_req_c = m0.read_req | m0.write_req;
    assign m1_req_c = m1.read_req | m1.write_req;
    assign m0_pkt_c = '{addr: m0.addr, wdata: m0.wdata, size: m0.size, wr: m0.write_req};
    assign m1_pkt_c = '{addr: m1.addr, wdata: m1.wdata, size: m1.size, wr: m1.write_req};
    assign pick1_c  = m1_req_c & (~m0_req_c | ~last_q);
    assign sel_pkt_c = pick1_c ? m1_pkt_c : m0_pkt_c;

`ifdef PBUS_ARB_TIMEOUT_EN
    localparam int unsigned CW = 8;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter is zero outside BUSY, so it is already clear on entry.
    always_comb begin
        cnt_d = '0;
        if (state_q == ST_BUSY && !s.ready) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_c = (state_q == ST_BUSY) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    assign expire_c = 1'b0;
`endif

    // Slave data wins over expiry; writes return zero; timeouts return all ones.
    assign rsp_data_c = s.ready ? (req_q.wr ? '0 : s.rdata) : '1;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        req_d      = req_q;
        s_addr_d   = '0;
        s_wdata_d  = '0;
        s_size_d   = '0;
        s_rd_d     = 1'b0;
        s_wr_d     = 1'b0;
        m0_rdata_d = '0;
        m1_rdata_d = '0;
        m0_ready_d = 1'b0;
        m1_ready_d = 1'b0;
        m0_err_d   = 1'b0;
        m1_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (m0_req_c || m1_req_c) begin
                    gnt_d     = pick1_c;
                    last_d    = pick1_c;
                    req_d     = sel_pkt_c;
                    s_addr_d  = sel_pkt_c.addr;
                    s_wdata_d = sel_pkt_c.wdata;
                    s_size_d  = sel_pkt_c.size;
                    s_wr_d    = sel_pkt_c.wr;
                    s_rd_d    = ~sel_pkt_c.wr;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (s.ready || expire_c) begin
                    state_d = ST_DONE;
                    if (gnt_q) begin
                        m1_ready_d = 1'b1;
                        m1_rdata_d = rsp_data_c;
                        m1_err_d   = ~s.ready;
                    end else begin
                        m0_ready_d = 1'b1;
                        m0_rdata_d = rsp_data_c;
                        m0_err_d   = ~s.ready;
                    end
                end else begin
                    s_addr_d  = req_q.addr;
                    s_wdata_d = req_q.wdata;
                    s_size_d  = req_q.size;
                    s_wr_d    = req_q.wr;
                    s_rd_d    = ~req_q.wr;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            gnt_q      <= 1'b0;
            req_q      <= '0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            s_size_q   <= '0;
            s_rd_q     <= 1'b0;
            s_wr_q     <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            m0_ready_q <= 1'b0;
            m1_ready_q <= 1'b0;
            m0_err_q   <= 1'b0;
            m1_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            req_q      <= req_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            s_size_q   <= s_size_d;
            s_rd_q     <= s_rd_d;
            s_wr_q     <= s_wr_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            m0_ready_q <= m0_ready_d;
            m1_ready_q <= m1_ready_d;
            m0_err_q   <= m0_err_d;
            m1_err_q   <= m1_err_d;
        end
    end

    assign s.addr      = s_addr_q;
    assign s.wdata     = s_wdata_q;
    assign s.size      = s_size_q;
    assign s.read_req  = s_rd_q;
    assign s.write_req = s_wr_q;
    assign m0.rdata    = m0_rdata_q;
    assign m0.ready    = m0_ready_q;
    assign m0.err      = m0_err_q;
    assign m1.rdata    = m1_rdata_q;
    assign m1.ready    = m1_ready_q;
    assign m1.err      = m1_err_q;
endmodule

// File: tb/tb_pbus_arbiter.sv
// Scoreboard bench for pbus_arbiter: slave model checks strobes, master monitor checks responses.
module tb_pbus_arbiter;
    localparam int unsigned TMO = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    pbus_arbiter_if m0_if ();
    pbus_arbiter_if m1_if ();
    pbus_arbiter_if s_if ();

    pbus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [2:0]  size;
        logic        wr;
        int          stall;
        int          exp_len;
    } sx_t;

    typedef struct {
        int          m;
        logic [31:0] rdata;
        logic        err;
    } mx_t;

    sx_t sq[$];
    mx_t mq[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_m(input int m, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] size, input logic rd, input logic wr);
        if (m == 0) begin
            m0_if.addr = addr; m0_if.wdata = wdata; m0_if.size = size;
            m0_if.read_req = rd; m0_if.write_req = wr;
        end else begin
            m1_if.addr = addr; m1_if.wdata = wdata; m1_if.size = size;
            m1_if.read_req = rd; m1_if.write_req = wr;
        end
    endtask

    task automatic expect_x(input int m, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [2:0] size, input logic wr, input int stall,
                            input logic [31:0] srdata, input int exp_len,
                            input logic err, input logic [31:0] mrdata);
        sx_t s;
        mx_t r;
        s.addr = addr; s.wdata = wdata; s.size = size; s.wr = wr;
        s.stall = stall; s.rdata = srdata; s.exp_len = exp_len;
        r.m = m; r.rdata = mrdata; r.err = err;
        sq.push_back(s);
        mq.push_back(r);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Drive one request, hold it until the ready pulse, optionally drop it early.
    task automatic issue(input int m, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] size, input logic rd, input logic wr,
                         input int exp_lat, input int drop_after);
        int cnt;
        bit seen;
        cnt  = 0;
        seen = 1'b0;
        set_m(m, addr, wdata, size, rd, wr);
        while (!seen && cnt < 100) begin
            @(negedge clock);
            cnt++;
            if (cnt == drop_after) set_m(m, addr, wdata, size, 1'b0, 1'b0);
            seen = (m == 0) ? m0_if.ready : m1_if.ready;
        end
        if (!seen) check("ready_timeout", 0, 1);
        else if (exp_lat >= 0) check("latency", cnt, exp_lat);
        set_m(m, addr, wdata, size, 1'b0, 1'b0);
    endtask

    // Slave model: checks the strobe phase and answers after cur.stall wait cycles.
    bit          s_act = 1'b0;
    int          s_len = 0;
    sx_t         cur;
    logic [31:0] w0;

    initial begin
        s_if.err   = 1'b0;
        s_if.ready = 1'b0;
        s_if.rdata = '0;
    end

    always @(negedge clock) begin : slave_model
        if (s_if.read_req || s_if.write_req) begin
            if (!s_act) begin
                s_act = 1'b1;
                s_len = 0;
                w0    = s_if.wdata;
                if (sq.size() == 0) begin
                    check("sq_empty", 1, 0);
                    cur.stall = 0; cur.exp_len = -1; cur.rdata = '0; cur.wr = 1'b0;
                end else begin
                    cur = sq.pop_front();
                    check("s_addr", s_if.addr, cur.addr);
                    check("s_wdata", s_if.wdata, cur.wdata);
                    check("s_size", s_if.size, cur.size);
                    check("s_op", {s_if.write_req, s_if.read_req}, {cur.wr, ~cur.wr});
                end
            end else begin
                check("s_wdata_hold", s_if.wdata, w0);
            end
            s_len++;
            s_if.ready = (s_len - 1 == cur.stall);
            s_if.rdata = s_if.ready ? cur.rdata : $urandom;
        end else begin
            if (s_act) begin
                s_act = 1'b0;
                if (cur.exp_len >= 0) check("s_len", s_len, cur.exp_len);
            end
            s_if.ready = 1'($urandom_range(0, 1));
            s_if.rdata = $urandom;
        end
    end

    // Master monitor: every ready pulse must match the next scoreboard entry.
    bit p0 = 1'b0;
    bit p1 = 1'b0;

    task automatic mon(input int m);
        mx_t         e;
        logic [31:0] rd;
        logic        er;
        rd = (m == 0) ? m0_if.rdata : m1_if.rdata;
        er = (m == 0) ? m0_if.err : m1_if.err;
        if (m == 0) check("other_idle", {m1_if.ready, m1_if.err, m1_if.rdata}, 0);
        else        check("other_idle", {m0_if.ready, m0_if.err, m0_if.rdata}, 0);
        if (mq.size() == 0) begin
            check("mq_empty", 1, 0);
        end else begin
            e = mq.pop_front();
            check("rdy_master", m, e.m);
            check("m_rdata", rd, e.rdata);
            check("m_err", er, e.err);
        end
    endtask

    always @(negedge clock) begin : master_mon
        if (m0_if.ready) mon(0);
        if (m1_if.ready) mon(1);
        if (m0_if.ready && p0) check("m0_pulse", 1, 0);
        if (m1_if.ready && p1) check("m1_pulse", 1, 0);
        p0 = m0_if.ready;
        p1 = m1_if.ready;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int  cnt;
        bit  seen;
        sx_t sx;

        // Reset held with both masters requesting.
        set_m(0, 32'hC000_0000, 32'h0, 3'b100, 1'b1, 1'b0);
        set_m(1, 32'hC000_0008, 32'h0, 3'b100, 1'b1, 1'b0);
        repeat (3) begin
            @(negedge clock);
            check("rst_s_addr", s_if.addr, 0);
            check("rst_s_ctl", {s_if.wdata, s_if.size, s_if.read_req, s_if.write_req}, 0);
            check("rst_m0", {m0_if.rdata, m0_if.ready, m0_if.err}, 0);
            check("rst_m1", {m1_if.rdata, m1_if.ready, m1_if.err}, 0);
        end
        expect_x(0, 32'hC000_0000, 32'h0, 3'b100, 1'b0, 0, 32'h0000_AAAA, 1, 1'b0, 32'h0000_AAAA);
        expect_x(1, 32'hC000_0008, 32'h0, 3'b100, 1'b0, 1, 32'hBBBB_0000, 2, 1'b0, 32'hBBBB_0000);
        reset = 1'b1;
        fork
            issue(0, 32'hC000_0000, 32'h0, 3'b100, 1'b1, 1'b0, 2, -1);
            issue(1, 32'hC000_0008, 32'h0, 3'b100, 1'b1, 1'b0, -1, -1);
        join
        idle(2);

        // Single read, slave answers in the first BUSY cycle.
        expect_x(0, 32'hC000_0004, 32'h0, 3'b100, 1'b0, 0, 32'h1234_5678, 1, 1'b0, 32'h1234_5678);
        issue(0, 32'hC000_0004, 32'h0, 3'b100, 1'b1, 1'b0, 2, -1);
        idle(2);

        // Request dropped mid-BUSY still completes.
        expect_x(0, 32'hC000_0030, 32'h1111_1111, 3'b010, 1'b0, 3, 32'hCAFE_F00D, 4, 1'b0, 32'hCAFE_F00D);
        issue(0, 32'hC000_0030, 32'h1111_1111, 3'b010, 1'b1, 1'b0, 5, 1);
        idle(2);

        // Stalled write from m1: six strobe cycles, write returns zero.
        expect_x(1, 32'hC000_0010, 32'hDEAD_BEEF, 3'b001, 1'b1, 5, 32'hA5A5_A5A5, 6, 1'b0, 32'h0);
        issue(1, 32'hC000_0010, 32'hDEAD_BEEF, 3'b001, 1'b0, 1'b1, 7, -1);
        idle(2);

        // Contention with m1 last granted: expect m0, m1, m0, m1.
        expect_x(0, 32'hC000_0100, 32'h0, 3'b100, 1'b0, 0, 32'h0101_0101, 1, 1'b0, 32'h0101_0101);
        expect_x(1, 32'hC000_0200, 32'h2222_0000, 3'b100, 1'b1, 2, 32'hA5A5_A5A5, 3, 1'b0, 32'h0);
        expect_x(0, 32'hC000_0108, 32'h0, 3'b010, 1'b0, 1, 32'h0303_0303, 2, 1'b0, 32'h0303_0303);
        expect_x(1, 32'hC000_0208, 32'h4444_0000, 3'b001, 1'b1, 0, 32'hA5A5_A5A5, 1, 1'b0, 32'h0);
        fork
            begin
                issue(0, 32'hC000_0100, 32'h0, 3'b100, 1'b1, 1'b0, -1, -1);
                issue(0, 32'hC000_0108, 32'h0, 3'b010, 1'b1, 1'b0, -1, -1);
            end
            begin
                issue(1, 32'hC000_0200, 32'h2222_0000, 3'b100, 1'b0, 1'b1, -1, -1);
                issue(1, 32'hC000_0208, 32'h4444_0000, 3'b001, 1'b0, 1'b1, -1, -1);
            end
        join
        idle(2);

        // Read and write together are treated as a write.
        expect_x(0, 32'hC000_0020, 32'h55AA_55AA, 3'b010, 1'b1, 1, 32'hA5A5_A5A5, 2, 1'b0, 32'h0);
        issue(0, 32'hC000_0020, 32'h55AA_55AA, 3'b010, 1'b1, 1'b1, 3, -1);
        idle(2);

`ifdef PBUS_ARB_TIMEOUT_EN
        expect_x(0, 32'hC000_0040, 32'h0, 3'b100, 1'b0, 1000, 32'h0, TMO, 1'b1, 32'hFFFF_FFFF);
        issue(0, 32'hC000_0040, 32'h0, 3'b100, 1'b1, 1'b0, TMO + 1, -1);
        idle(2);
        expect_x(0, 32'hC000_0044, 32'h0, 3'b100, 1'b0, TMO - 1, 32'h8765_4321, TMO, 1'b0, 32'h8765_4321);
        issue(0, 32'hC000_0044, 32'h0, 3'b100, 1'b1, 1'b0, TMO + 1, -1);
        idle(2);
`else
        expect_x(0, 32'hC000_0040, 32'h0, 3'b100, 1'b0, 10, 32'h8765_4321, 11, 1'b0, 32'h8765_4321);
        issue(0, 32'hC000_0040, 32'h0, 3'b100, 1'b1, 1'b0, 12, -1);
        idle(2);
`endif

        // Reset during BUSY: strobe drops, no ready, no replay.
        sx.addr = 32'hC000_0050; sx.wdata = 32'h0; sx.size = 3'b100; sx.wr = 1'b0;
        sx.stall = 1000; sx.rdata = 32'h0; sx.exp_len = -1;
        sq.push_back(sx);
        set_m(0, 32'hC000_0050, 32'h0, 3'b100, 1'b1, 1'b0);
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 10) begin
            @(negedge clock);
            cnt++;
            seen = s_if.read_req;
        end
        if (!seen) check("busy_timeout", 0, 1);
        @(negedge clock);
        reset = 1'b0;
        set_m(0, 32'hC000_0050, 32'h0, 3'b100, 1'b0, 1'b0);
        @(negedge clock);
        check("rst_strobe_drop", {s_if.read_req, s_if.write_req}, 0);
        check("rst_no_ready", m0_if.ready, 0);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clock);
            check("post_rst_quiet", {m0_if.ready, s_if.read_req}, 0);
        end

        check("sq_drain", sq.size(), 0);
        check("mq_drain", mq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
